// File: rtl/stopwatch_counter.sv
// Four-digit BCD MM:SS stopwatch: counts rising edges of `step` from 00:00 to 59:59 under start/stop/clear control.
// Optional lap hold is enabled by defining STOPWATCH_LAP_EN.
module stopwatch_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       step,
  input  logic       lap,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       running,
  output logic       min_tick,
  output logic       overflow,
  output logic       lap_hold
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [3:0] sec_ones_reg, sec_tens_reg, min_ones_reg, min_tens_reg;
  logic       step_q;
  logic       min_tick_reg, overflow_reg;
  logic       tick, count_en;
  logic       carry_s1, carry_s10, carry_m1, carry_m10;

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // clear beats stop beats start; a simultaneous start+stop never enters RUN
  always_comb begin
    state_next = state_reg;
    if (clear) begin
      state_next = IDLE;
    end else if (stop) begin
      if (state_reg == RUN) state_next = PAUSE;
    end else if (start) begin
      if (state_reg != RUN) state_next = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) step_q <= 1'b0;
    else       step_q <= step;
  end

  assign tick     = step & ~step_q;
  assign count_en = tick && (state_reg == RUN) && !stop && !clear;

  assign carry_s1  = (sec_ones_reg == 4'd9);
  assign carry_s10 = carry_s1 && (sec_tens_reg == 4'd5);
  assign carry_m1  = carry_s10 && (min_ones_reg == 4'd9);
  assign carry_m10 = carry_m1 && (min_tens_reg == 4'd5);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      sec_ones_reg <= 4'd0;
      sec_tens_reg <= 4'd0;
      min_ones_reg <= 4'd0;
      min_tens_reg <= 4'd0;
      min_tick_reg <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      min_tick_reg <= 1'b0;
      if (count_en) begin
        sec_ones_reg <= carry_s1 ? 4'd0 : sec_ones_reg + 4'd1;
        if (carry_s1)
          sec_tens_reg <= carry_s10 ? 4'd0 : sec_tens_reg + 4'd1;
        if (carry_s10) begin
          min_ones_reg <= carry_m1 ? 4'd0 : min_ones_reg + 4'd1;
          min_tick_reg <= 1'b1;
        end
        if (carry_m1)
          min_tens_reg <= carry_m10 ? 4'd0 : min_tens_reg + 4'd1;
        if (carry_m10)
          overflow_reg <= 1'b1;
      end
    end
  end

  assign running  = (state_reg == RUN);
  assign min_tick = min_tick_reg;
  assign overflow = overflow_reg;

`ifdef STOPWATCH_LAP_EN
  logic [3:0] lap_s1_reg, lap_s10_reg, lap_m1_reg, lap_m10_reg;
  logic       lap_hold_reg;

  // Snapshot takes the pre-increment digits, i.e. the value on display at the lap edge
  always_ff @(posedge clk) begin
    if (reset) begin
      lap_s1_reg   <= 4'd0;
      lap_s10_reg  <= 4'd0;
      lap_m1_reg   <= 4'd0;
      lap_m10_reg  <= 4'd0;
      lap_hold_reg <= 1'b0;
    end else if (clear) begin
      lap_hold_reg <= 1'b0;
    end else if (lap && (state_reg != IDLE)) begin
      if (lap_hold_reg) begin
        lap_hold_reg <= 1'b0;
      end else begin
        lap_s1_reg   <= sec_ones_reg;
        lap_s10_reg  <= sec_tens_reg;
        lap_m1_reg   <= min_ones_reg;
        lap_m10_reg  <= min_tens_reg;
        lap_hold_reg <= 1'b1;
      end
    end
  end

  assign lap_hold = lap_hold_reg;
  assign sec_ones = lap_hold_reg ? lap_s1_reg  : sec_ones_reg;
  assign sec_tens = lap_hold_reg ? lap_s10_reg : sec_tens_reg;
  assign min_ones = lap_hold_reg ? lap_m1_reg  : min_ones_reg;
  assign min_tens = lap_hold_reg ? lap_m10_reg : min_tens_reg;
`else
  logic unused_lap;
  assign unused_lap = lap;

  assign lap_hold = 1'b0;
  assign sec_ones = sec_ones_reg;
  assign sec_tens = sec_tens_reg;
  assign min_ones = min_ones_reg;
  assign min_tens = min_tens_reg;
`endif

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter; expected MM:SS values are hand-computed BCD constants.
// Lap checks follow STOPWATCH_LAP_EN so the same bench covers both builds.
module tb_stopwatch_counter;

  logic       clk = 1'b0;
  logic       reset, start, stop, clear, step, lap;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
  logic       running, min_tick, overflow, lap_hold;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int mt_count = 0;
  int not_running = 0;
  bit watch_run = 1'b0;

  stopwatch_counter dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .clear    (clear),
    .step     (step),
    .lap      (lap),
    .sec_ones (sec_ones),
    .sec_tens (sec_tens),
    .min_ones (min_ones),
    .min_tens (min_tens),
    .running  (running),
    .min_tick (min_tick),
    .overflow (overflow),
    .lap_hold (lap_hold)
  );

  always #5 clk = ~clk;

  // Outputs are observed on the falling edge, half a cycle after each update
  always @(negedge clk) begin
    if (min_tick) mt_count++;
    if (watch_run && !running) not_running++;
  end

  function automatic logic [15:0] disp();
    return {min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1; @(negedge clk); start = 1'b0; @(negedge clk);
  endtask

  task automatic pulse_stop();
    stop = 1'b1; @(negedge clk); stop = 1'b0; @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; step = 1'b0; lap = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_disp",     disp(),   16'h0000);
    check("reset_running",  running,  16'h0);
    check("reset_min_tick", min_tick, 16'h0);
    check("reset_overflow", overflow, 16'h0);
    check("reset_lap_hold", lap_hold, 16'h0);

    ticks(3);
    check("idle_no_count", disp(), 16'h0000);

    pulse_start();
    check("start_running", running, 16'h1);
    watch_run = 1'b1;
    ticks(10);
    watch_run = 1'b0;
    check("ten_ticks",       disp(),      16'h0010);
    check("ten_running",     not_running, 16'h0);
    check("ten_no_min_tick", mt_count,    16'h0);

    ticks(49);
    check("at_0059", disp(), 16'h0059);
    ticks(1);
    check("wrap_0100",      disp(),   16'h0100);
    check("min_tick_once",  mt_count, 16'h1);
    check("no_overflow",    overflow, 16'h0);

    pulse_stop();
    check("stop_running", running, 16'h0);
    ticks(1);
    check("pause_hold", disp(), 16'h0100);

    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    @(negedge clk);
    check("start_stop_pause", running, 16'h0);
    ticks(1);
    check("start_stop_hold", disp(), 16'h0100);

    pulse_start();
    step = 1'b1; stop = 1'b1;
    @(negedge clk);
    step = 1'b0; stop = 1'b0;
    @(negedge clk);
    check("tick_with_stop", disp(),  16'h0100);
    check("stopped_again",  running, 16'h0);

    step = 1'b1;
    repeat (2) @(negedge clk);
    pulse_start();
    step = 1'b0;
    @(negedge clk);
    check("held_step_no_tick", disp(),  16'h0100);
    check("held_step_running", running, 16'h1);
    ticks(1);
    check("after_held", disp(), 16'h0101);

    lap = 1'b1; @(negedge clk); lap = 1'b0; @(negedge clk);
`ifdef STOPWATCH_LAP_EN
    check("lap_set", lap_hold, 16'h1);
    ticks(5);
    check("lap_frozen",    disp(),   16'h0101);
    check("lap_hold_kept", lap_hold, 16'h1);
`else
    check("lap_ignored", lap_hold, 16'h0);
    ticks(5);
    check("lap_live", disp(), 16'h0106);
`endif
    lap = 1'b1; @(negedge clk); lap = 1'b0; @(negedge clk);
    check("lap_release", disp(),   16'h0106);
    check("lap_off",     lap_hold, 16'h0);

    ticks(688);
    check("at_1234", disp(), 16'h1234);
    reset = 1'b1; step = 1'b1;
    @(negedge clk);
    reset = 1'b0; step = 1'b0;
    @(negedge clk);
    check("midrun_reset_disp",    disp(),   16'h0000);
    check("midrun_reset_running", running,  16'h0);
    check("midrun_reset_ovf",     overflow, 16'h0);
    ticks(2);
    check("post_reset_idle", disp(), 16'h0000);

    pulse_start();
    mt_count = 0;
    ticks(3599);
    check("at_5959",       disp(),   16'h5959);
    check("mt_59",         mt_count, 16'd59);
    check("pre_overflow",  overflow, 16'h0);
    ticks(1);
    check("wrap_0000",     disp(),   16'h0000);
    check("overflow_set",  overflow, 16'h1);
    check("mt_60",         mt_count, 16'd60);
    ticks(5);
    check("after_wrap",    disp(),   16'h0005);
    check("overflow_sticky", overflow, 16'h1);

    clear = 1'b1; @(negedge clk); clear = 1'b0; @(negedge clk);
    check("clear_disp",     disp(),   16'h0000);
    check("clear_overflow", overflow, 16'h0);
    check("clear_running",  running,  16'h0);
    ticks(2);
    check("clear_idle", disp(), 16'h0000);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
